rle_tx_sequencer: RTL and testbench
===================================

// Module: rle_tx_sequencer
// PURPOSE
//  Controller between the UART receiver, the run-length encoder storage and the UART transmitter.
//  - Folds the incoming RX byte stream into (count, value) runs.
//  - Buffers the completed runs.
//  - On a flush request, schedules the UART TX to send each pair as two bytes: count, then value.
//  - Sits inside top, beside the uart_rx/uart_tx instances.
// PARAMETERS
//  DEPTH    16  pair buffer entries (power of 2, >=2)
//  MAX_RUN  255 largest count per pair; a longer run splits into several pairs
// PORTS
//  clk         in   1        system clock, all logic rising-edge
//  reset       in   1        asynchronous, active-low reset
//  rx_valid    in   1        one-cycle strobe: rx_data holds a received byte
//  rx_data     in   8        received byte
//  flush       in   1        level request (the t input of top); only the rising edge acts
//  tx_busy     in   1        UART TX busy; rises the cycle after an accepted tx_start
//  tx_start    out  1        one-cycle pulse launching a TX byte
//  tx_data     out  8        byte to send, valid while tx_start=1
//  busy        out  1        high in any SEND_* state
//  overflow    out  1        sticky flag; cleared only by reset
//  pair_count  out  $clog2(DEPTH+1)  pairs currently buffered
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=ACCUM, run register empty, buffer empty.
//  Run register: cur_val[7:0], cur_cnt[7:0], run_vld.
//  ACCUM state, when rx_valid=1:
//   - !run_vld: cur_val=rx_data, cur_cnt=1, run_vld=1.
//   - rx_data==cur_val and cur_cnt<MAX_RUN: cur_cnt+1 (count never wraps).
//   - otherwise: push {cur_cnt,cur_val} to the buffer, then cur_val=rx_data, cur_cnt=1.
//  Push while buffer full: pair dropped, overflow<=1, buffer unchanged.
//  Flush edge: flush_q registers flush; edge = flush & ~flush_q, detected in ACCUM only.
//   - Edge with rx_valid in the same cycle: the byte is folded first, the flush acts the next cycle.
//   - Edge, run_vld=1: push the pending run (overflow rule applies), clear run_vld, go to SEND_CNT.
//   - Edge, run_vld=0, buffer non-empty: go to SEND_CNT.
//   - Edge, run_vld=0, buffer empty: no TX, stay in ACCUM.
//  SEND_CNT: when tx_busy=0, assert tx_start=1 with tx_data=head.count for exactly 1 cycle -> WAIT_HI_C.
//  WAIT_HI_C: wait for tx_busy=1 -> WAIT_LO_C.
//  WAIT_LO_C: wait for tx_busy=0 -> SEND_VAL.
//  SEND_VAL / WAIT_HI_V / WAIT_LO_V: same handshake with tx_data=head.value.
//   - The pop happens on leaving WAIT_LO_V.
//   - Then: buffer non-empty -> SEND_CNT; empty -> ACCUM.
//  tx_start is never asserted while tx_busy=1; at most one tx_start per byte.
//  Latency: flush edge sampled at edge N (tx_busy=0) -> tx_start high in cycle N+2.
//  rx_valid during SEND_*: byte dropped, overflow<=1.
//  Flush held high across a whole SEND: no re-trigger until flush falls and rises again.
//  pair_count updates the cycle after a push/pop; simultaneous push+pop cannot occur (pops only in SEND).
//  Async reset mid-SEND: tx_start drops immediately; FSM, run register and buffer are cleared.
// STRUCTURE
//  Package rle_pkg:
//   - typedef struct packed {logic [7:0] count; logic [7:0] value;} rle_pair_t
//   - typedef enum rle_seq_state_t {ACCUM, SEND_CNT, WAIT_HI_C, WAIT_LO_C, SEND_VAL, WAIT_HI_V, WAIT_LO_V}
//   - localparam MAX_RUN_DEF = 255
//  Sub-module rle_pair_fifo: synchronous FIFO of rle_pair_t.
//   - Ports: push, pop, full, empty, count.
//   - Read/write pointers are $clog2(DEPTH) bits and wrap.
//  Top level: FSM, run register and flush edge detector only.
// TESTING
//  Bench uses a TX model: busy rises 1 cycle after tx_start, held 20 cycles.
//  1. RX 55,55,66,66,61,66; flush 0->1 -> TX bytes 02,55,02,66,01,61,01,66; busy falls; pair_count=0.
//  2. RX 300 x 0xAA; flush -> TX FF,AA,2D,AA (255+45 split).
//  3. DEPTH=4: RX 6 distinct bytes -> overflow=1 at 5th push; flush sends the first 4 pairs, then the pending run is dropped.
//  4. Flush with nothing received -> no tx_start within 100 cycles; busy stays 0.
//  5. rx_valid during SEND -> overflow=1; TX sequence unchanged.
//  6. Reset low mid WAIT_LO_C -> all outputs 0 next cycle; RX 41 + flush -> TX 01,41 only.
//  All cases: assert tx_start never coincides with tx_busy=1, and each tx_start lasts exactly 1 cycle.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and defaults for the run-length TX sequencer.
package rle_pkg;

    // One buffered run: how many times value repeated.
    typedef struct packed {
        logic [7:0] count;
        logic [7:0] value;
    } rle_pair_t;

    typedef enum logic [2:0] {
        ACCUM,
        SEND_CNT,
        WAIT_HI_C,
        WAIT_LO_C,
        SEND_VAL,
        WAIT_HI_V,
        WAIT_LO_V
    } rle_seq_state_t;

    localparam int unsigned MAX_RUN_DEF = 255;

endpackage

// File: rtl/rle_tx_sequencer_if.sv
// RX/TX handshake and status bundle between the sequencer and its surroundings.
interface rle_tx_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            flush;
    logic            tx_busy;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            busy;
    logic            overflow;
    logic [CntW-1:0] pair_count;

    // Environment side: UART RX, flush request and UART TX busy.
    modport master (
        output rx_valid, rx_data, flush, tx_busy,
        input  tx_start, tx_data, busy, overflow, pair_count
    );

    // Sequencer side.
    modport slave (
        input  rx_valid, rx_data, flush, tx_busy,
        output tx_start, tx_data, busy, overflow, pair_count
    );

endinterface

// File: rtl/rle_pair_fifo.sv
// Synchronous FIFO of (count, value) pairs with a combinational head.
module rle_pair_fifo
    import rle_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  rle_pair_t                    push_data,
    input  logic                         pop,
    output rle_pair_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    rle_pair_t       mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    // A push into a full FIFO and a pop from an empty one are ignored.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/rle_tx_sequencer.sv
// Folds RX bytes into runs, buffers them and replays them as count/value byte pairs
// through the UART TX on a rising flush request.
module rle_tx_sequencer
    import rle_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_RUN = MAX_RUN_DEF
) (
    input logic                clk,
    input logic                reset,
    rle_tx_sequencer_if.slave  bus
);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam logic [7:0]  MaxRun = 8'(MAX_RUN);

    rle_seq_state_t  state_q, state_d;
    logic            flush_q;
    logic            flush_pend_q, flush_pend_d;
    logic [7:0]      cur_val_q, cur_val_d;
    logic [7:0]      cur_cnt_q, cur_cnt_d;
    logic            run_vld_q, run_vld_d;
    logic            overflow_q, overflow_d;
    logic            flush_edge, flush_req;
    logic            push, pop;
    rle_pair_t       push_pair, head;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            tx_start;
    logic [7:0]      tx_data;

    // A flush edge coinciding with an RX byte is parked in flush_pend and acted on next cycle.
    assign flush_edge = bus.flush & ~flush_q;
    assign flush_req  = (state_q == ACCUM) & (flush_edge | flush_pend_q);
    assign push_pair  = '{count: cur_cnt_q, value: cur_val_q};

    rle_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_pair),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State, run register, flush history and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ACCUM;
            flush_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            cur_val_q    <= 8'h00;
            cur_cnt_q    <= 8'h00;
            run_vld_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= bus.flush;
            flush_pend_q <= flush_pend_d;
            cur_val_q    <= cur_val_d;
            cur_cnt_q    <= cur_cnt_d;
            run_vld_q    <= run_vld_d;
            overflow_q   <= overflow_d;
        end
    end

    // Run folding, pushes of completed runs and overflow detection.
    always_comb begin
        cur_val_d    = cur_val_q;
        cur_cnt_d    = cur_cnt_q;
        run_vld_d    = run_vld_q;
        flush_pend_d = 1'b0;
        overflow_d   = overflow_q;
        push         = 1'b0;
        if (state_q == ACCUM) begin
            if (bus.rx_valid) begin
                flush_pend_d = flush_req;
                if (run_vld_q && bus.rx_data == cur_val_q && cur_cnt_q < MaxRun) begin
                    cur_cnt_d = cur_cnt_q + 8'd1;
                end else begin
                    push      = run_vld_q;
                    cur_val_d = bus.rx_data;
                    cur_cnt_d = 8'd1;
                    run_vld_d = 1'b1;
                end
            end else if (flush_req && run_vld_q) begin
                push      = 1'b1;
                run_vld_d = 1'b0;
            end
        end else if (bus.rx_valid) begin
            // No room to fold bytes while transmitting.
            overflow_d = 1'b1;
        end
        if (push && fifo_full) overflow_d = 1'b1;
    end

    // Next-state logic: flush start, then a busy high/low handshake per byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: begin
                if (flush_req && !bus.rx_valid && (run_vld_q || !fifo_empty)) begin
                    state_d = SEND_CNT;
                end
            end
            SEND_CNT:  if (!bus.tx_busy) state_d = WAIT_HI_C;
            WAIT_HI_C: if (bus.tx_busy)  state_d = WAIT_LO_C;
            WAIT_LO_C: if (!bus.tx_busy) state_d = SEND_VAL;
            SEND_VAL:  if (!bus.tx_busy) state_d = WAIT_HI_V;
            WAIT_HI_V: if (bus.tx_busy)  state_d = WAIT_LO_V;
            WAIT_LO_V: begin
                // The head is popped on this transition, so one entry left means empty after.
                if (!bus.tx_busy) state_d = (fifo_count > CntW'(1)) ? SEND_CNT : ACCUM;
            end
            default:   state_d = ACCUM;
        endcase
    end

    // Outputs: one-cycle tx_start with the head byte, and pop when the pair is done.
    always_comb begin
        tx_start = 1'b0;
        tx_data  = 8'h00;
        pop      = 1'b0;
        unique case (state_q)
            SEND_CNT: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = head.count;
                end
            end
            SEND_VAL: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = head.value;
                end
            end
            WAIT_LO_V: pop = ~bus.tx_busy;
            default: ;
        endcase
    end

    assign bus.tx_start   = tx_start;
    assign bus.tx_data    = tx_data;
    assign bus.busy       = (state_q != ACCUM);
    assign bus.overflow   = overflow_q;
    assign bus.pair_count = fifo_count;

endmodule

// File: tb/tb_rle_tx_sequencer.sv
// Self-checking bench for rle_tx_sequencer with a UART TX busy model.
module tb_rle_tx_sequencer;
    localparam int unsigned Depth = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rle_tx_sequencer_if #(.DEPTH(Depth)) bus ();

    rle_tx_sequencer #(
        .DEPTH   (Depth),
        .MAX_RUN (255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         busy_cnt = 0;
    bit         prev_start = 1'b0;
    bit         exp_ovf  = 1'b0;
    logic [7:0] tx_log[$];
    int         cyc_log[$];
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: log every TX byte and check the start-pulse rules.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            chk("start_while_busy", 32'(bus.tx_busy), 0);
            chk("start_width", 32'(prev_start), 0);
            tx_log.push_back(bus.tx_data);
            cyc_log.push_back(cyc);
        end
        prev_start = (bus.tx_start === 1'b1);
    end

    // UART TX model: busy rises one cycle after tx_start and stays 20 cycles.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (prev_start) busy_cnt = 20;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        #1 bus.tx_busy = (busy_cnt != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: group stim_q into maximal runs, split each into <=255 chunks,
    // keep the first Depth chunks; anything beyond that is lost and flags overflow.
    function automatic bit model_build();
        logic [7:0] runs_v[$];
        int         runs_l[$];
        int         pieces = 0;
        exp_q.delete();
        foreach (stim_q[i]) begin
            if (runs_v.size() > 0 && runs_v[runs_v.size()-1] == stim_q[i]) begin
                runs_l[runs_l.size()-1] += 1;
            end else begin
                runs_v.push_back(stim_q[i]);
                runs_l.push_back(1);
            end
        end
        foreach (runs_v[r]) begin
            int left = runs_l[r];
            while (left > 0) begin
                int c = (left > 255) ? 255 : left;
                if (pieces < int'(Depth)) begin
                    exp_q.push_back(8'(c));
                    exp_q.push_back(runs_v[r]);
                end
                pieces++;
                left -= c;
            end
        end
        return pieces > int'(Depth);
    endfunction

    task automatic rx_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_overflow"}, 32'(bus.overflow), 0);
        chk({tag, "_pair_count"}, 32'(bus.pair_count), 0);
    endtask

    // Raise flush (optionally with a final RX byte), wait for the send to finish,
    // then compare the TX bytes against exp_q.
    task automatic run_flush(input string tag, input bit with_byte, input logic [7:0] last_b,
                             input bit inject);
        int base;
        int fcyc;
        bit idle;
        bit injected;
        int lat;
        @(posedge clk);
        #1;
        base     = tx_log.size();
        idle     = (bus.tx_busy == 1'b0);
        injected = 1'b0;
        if (with_byte) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = last_b;
        end
        bus.flush = 1'b1;
        fcyc      = cyc;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (inject && !injected && tx_log.size() > base) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = 8'h99;
                injected     = 1'b1;
            end
            if (i >= 3 && !bus.busy) break;
        end
        bus.rx_valid = 1'b0;
        bus.flush    = 1'b0;
        chk({tag, "_idle"}, 32'(bus.busy), 0);
        chk({tag, "_len"}, tx_log.size() - base, exp_q.size());
        foreach (exp_q[k]) begin
            if (base + k < tx_log.size()) begin
                chk($sformatf("%s_byte%0d", tag, k), 32'(tx_log[base+k]), 32'(exp_q[k]));
            end
        end
        if (exp_q.size() > 0 && idle && tx_log.size() > base) begin
            lat = cyc_log[base] - fcyc;
            chk({tag, "_latency"}, 32'(lat >= 1 && lat <= 2), 1);
        end
        chk({tag, "_pair_count"}, 32'(bus.pair_count), 0);
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    endtask

    task automatic play(input string tag, input bit with_byte, input bit inject);
        int n = stim_q.size();
        for (int i = 0; i < n - (with_byte ? 1 : 0); i++) rx_byte(stim_q[i]);
        run_flush(tag, with_byte, stim_q[n-1], inject);
    endtask

    initial begin
        int         base;
        int         nr;
        int         len;
        bit         busy_seen;
        bit         long_used;
        bit         wb;
        bit         reached;
        logic [7:0] v;
        logic [7:0] prev;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        reset = 1'b1;

        // Flush with nothing received: no TX at all.
        @(posedge clk);
        #1;
        base      = tx_log.size();
        busy_seen = 1'b0;
        bus.flush = 1'b1;
        repeat (100) begin
            @(negedge clk);
            busy_seen |= bus.busy;
        end
        bus.flush = 1'b0;
        chk("empty_flush_len", tx_log.size() - base, 0);
        chk("empty_flush_busy", 32'(busy_seen), 0);

        // Mixed runs.
        stim_q = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h61, 8'h66};
        foreach (stim_q[i]) rx_byte(stim_q[i]);
        chk("t1_pairs_before_flush", 32'(bus.pair_count), 3);
        exp_q = '{8'h02, 8'h55, 8'h02, 8'h66, 8'h01, 8'h61, 8'h01, 8'h66};
        run_flush("t1", 1'b0, 8'h00, 1'b0);

        // 300-byte run splits at 255; last byte arrives with the flush edge.
        stim_q.delete();
        repeat (300) stim_q.push_back(8'hAA);
        exp_q = '{8'hFF, 8'hAA, 8'h2D, 8'hAA};
        play("t2", 1'b1, 1'b0);

        // Randomized run patterns against the reference model.
        for (int r = 0; r < 6; r++) begin
            stim_q.delete();
            nr        = $urandom_range(1, 3);
            long_used = 1'b0;
            prev      = 8'h00;
            for (int j = 0; j < nr; j++) begin
                do v = 8'($urandom_range(0, 255)); while (j > 0 && v == prev);
                if (!long_used && $urandom_range(0, 2) == 0) begin
                    len       = $urandom_range(250, 300);
                    long_used = 1'b1;
                end else begin
                    len = $urandom_range(1, 6);
                end
                repeat (len) stim_q.push_back(v);
                prev = v;
            end
            exp_ovf |= model_build();
            wb = 1'($urandom_range(0, 1));
            play($sformatf("rnd%0d", r), wb, 1'b0);
        end

        // RX byte during a send is dropped and flags overflow.
        stim_q = '{8'h07, 8'h07, 8'h08};
        void'(model_build());
        exp_ovf = 1'b1;
        play("t5", 1'b0, 1'b1);
        exp_q.delete();
        run_flush("t5_after", 1'b0, 8'h00, 1'b0);

        // Reset in the middle of the count handshake clears everything.
        stim_q = '{8'h10, 8'h10, 8'h20};
        foreach (stim_q[i]) rx_byte(stim_q[i]);
        @(posedge clk);
        #1;
        base      = tx_log.size();
        bus.flush = 1'b1;
        reached   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_log.size() > base && bus.tx_busy) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t6_reached_wait", 32'(reached), 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bus.flush = 1'b0;
        #1 check_zero("t6_async_reset");
        chk("t6_bytes_before_reset", tx_log.size() - base, 1);
        if (tx_log.size() > base) chk("t6_first_byte", 32'(tx_log[base]), 32'h02);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_ovf = 1'b0;
        rx_byte(8'h41);
        exp_q = '{8'h01, 8'h41};
        run_flush("t6", 1'b0, 8'h00, 1'b0);

        // Buffer overflow with six distinct bytes into four entries.
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 0; i < 5; i++) rx_byte(stim_q[i]);
        chk("t3_pairs_full", 32'(bus.pair_count), 4);
        chk("t3_no_overflow_yet", 32'(bus.overflow), 0);
        rx_byte(stim_q[5]);
        chk("t3_overflow_5th_push", 32'(bus.overflow), 1);
        chk("t3_pairs_still_full", 32'(bus.pair_count), 4);
        exp_ovf = 1'b1;
        exp_q   = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h01, 8'h04};
        run_flush("t3", 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
